// File: rtl/t03_fight_pkg.sv
// Shared encodings for the combat resolver slice.
//   - player state codes driven by the player FSMs (11 is treated as rest)
//   - resolver FSM state codes
//   - winner codes
//   - hit_evt_t: one attacker->defender resolution result
//   - sat_sub: health subtraction clamped at zero
package t03_fight_pkg;

  localparam logic [1:0] PS_REST   = 2'b00;
  localparam logic [1:0] PS_ATTACK = 2'b01;
  localparam logic [1:0] PS_BLOCK  = 2'b10;

  localparam logic [1:0] ST_FIGHT   = 2'd0;
  localparam logic [1:0] ST_HITSTOP = 2'd1;
  localparam logic [1:0] ST_OVER    = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef struct packed {
    logic hit;
    logic blocked;
  } hit_evt_t;

  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

endpackage

// File: rtl/t03_combat_resolver_if.sv
// Frame-level bus between the player FSMs / renderer and the resolver.
//   master: drives frame tick, player state, range and restart; reads results
//   slave : the resolver
interface t03_combat_resolver_if;
  logic       finished;
  logic [1:0] p1_state;
  logic [1:0] p2_state;
  logic       p1_resting;
  logic       p2_resting;
  logic       in_range;
  logic       restart;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic       p1_hit;
  logic       p2_hit;
  logic       p1_blocked;
  logic       p2_blocked;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output finished, p1_state, p2_state, p1_resting, p2_resting, in_range, restart,
    input  p1_health, p2_health, p1_hit, p2_hit, p1_blocked, p2_blocked, game_over, winner
  );

  modport slave (
    input  finished, p1_state, p2_state, p1_resting, p2_resting, in_range, restart,
    output p1_health, p2_health, p1_hit, p2_hit, p1_blocked, p2_blocked, game_over, winner
  );
endinterface

// File: rtl/t03_hit_detect.sv
// One attacker -> defender pair.
//   clk, rst      : clock, sync active-low reset
//   tick          : frame advance
//   eval_en       : resolver is in FIGHT, attacks may resolve this frame
//   clr           : clear the landed latch (round restart)
//   atk_state/atk_resting, def_state, in_range : frame inputs
//   evt           : combinational hit/block decision on the defender
// The landed latch makes each attack resolve at most once: it sets on
// resolution and only clears once the attacker leaves the attack state.
module t03_hit_detect
  import t03_fight_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       eval_en,
  input  logic       clr,
  input  logic [1:0] atk_state,
  input  logic       atk_resting,
  input  logic [1:0] def_state,
  input  logic       in_range,
  output hit_evt_t   evt
);
  logic landed;
  logic live;

  assign live = (atk_state == PS_ATTACK) && !atk_resting && in_range && !landed;

  always_comb begin
    evt = '0;
    if (eval_en && live) begin
      if (def_state == PS_BLOCK) evt.blocked = 1'b1;
      else                       evt.hit     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      landed <= 1'b0;
    else if (tick) begin
      if (clr || atk_state != PS_ATTACK) landed <= 1'b0;
      else if (evt.hit || evt.blocked)   landed <= 1'b1;
    end
  end
endmodule

// File: rtl/t03_combat_resolver.sv
// Combat resolver: turns both players' frame state into hits, blocks,
// health, hit-stop freeze and game-over. Advances only on frames
// (bus.finished=1); every output is registered.
//   clk, rst : clock, sync active-low reset (wins over a frame tick)
//   bus      : slave side of t03_combat_resolver_if
module t03_combat_resolver #(
  parameter logic [3:0] MAX_HEALTH     = 4'd10,
  parameter logic [3:0] DAMAGE         = 4'd2,
  parameter logic [2:0] HITSTOP_FRAMES = 3'd4
) (
  input logic                  clk,
  input logic                  rst,
  t03_combat_resolver_if.slave bus
);
  import t03_fight_pkg::*;

  // A zero-length freeze is not meaningful; it degrades to one frame.
  localparam logic [2:0] HS_LOAD = (HITSTOP_FRAMES == 3'd0) ? 3'd0 : HITSTOP_FRAMES - 3'd1;

  logic [1:0] fsm;
  logic [2:0] hs_cnt;
  logic [3:0] h1, h2;
  logic       hit1, hit2, blk1, blk2, over;
  logic [1:0] win;

  hit_evt_t   evt_on_p2, evt_on_p1;
  logic       fight, restart_now;
  logic [3:0] h1_nxt, h2_nxt;

  assign fight       = (fsm == ST_FIGHT);
  assign restart_now = (fsm == ST_OVER) && bus.restart;

  t03_hit_detect u_p1_atk (
    .clk, .rst, .tick(bus.finished), .eval_en(fight), .clr(restart_now),
    .atk_state(bus.p1_state), .atk_resting(bus.p1_resting),
    .def_state(bus.p2_state), .in_range(bus.in_range), .evt(evt_on_p2)
  );

  t03_hit_detect u_p2_atk (
    .clk, .rst, .tick(bus.finished), .eval_en(fight), .clr(restart_now),
    .atk_state(bus.p2_state), .atk_resting(bus.p2_resting),
    .def_state(bus.p1_state), .in_range(bus.in_range), .evt(evt_on_p1)
  );

  assign h1_nxt = evt_on_p1.hit ? sat_sub(h1, DAMAGE) : h1;
  assign h2_nxt = evt_on_p2.hit ? sat_sub(h2, DAMAGE) : h2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm    <= ST_FIGHT;
      hs_cnt <= 3'd0;
      h1     <= MAX_HEALTH;
      h2     <= MAX_HEALTH;
      hit1   <= 1'b0;
      hit2   <= 1'b0;
      blk1   <= 1'b0;
      blk2   <= 1'b0;
      over   <= 1'b0;
      win    <= WIN_NONE;
    end else if (bus.finished) begin
      // event flags are single-frame pulses
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      blk1 <= 1'b0;
      blk2 <= 1'b0;
      case (fsm)
        ST_FIGHT: begin
          hit1 <= evt_on_p1.hit;
          hit2 <= evt_on_p2.hit;
          blk1 <= evt_on_p1.blocked;
          blk2 <= evt_on_p2.blocked;
          h1   <= h1_nxt;
          h2   <= h2_nxt;
          // a knockout beats the hit-stop freeze
          if (h1_nxt == 4'd0 || h2_nxt == 4'd0) begin
            fsm  <= ST_OVER;
            over <= 1'b1;
            win  <= {h1_nxt == 4'd0, h2_nxt == 4'd0};
          end else if (evt_on_p1.hit || evt_on_p2.hit ||
                       evt_on_p1.blocked || evt_on_p2.blocked) begin
            fsm    <= ST_HITSTOP;
            hs_cnt <= HS_LOAD;
          end
        end
        ST_HITSTOP: begin
          if (hs_cnt == 3'd0) fsm    <= ST_FIGHT;
          else                hs_cnt <= hs_cnt - 3'd1;
        end
        ST_OVER: begin
          if (bus.restart) begin
            fsm  <= ST_FIGHT;
            h1   <= MAX_HEALTH;
            h2   <= MAX_HEALTH;
            over <= 1'b0;
            win  <= WIN_NONE;
          end
        end
        default: fsm <= ST_FIGHT;
      endcase
    end
  end

  assign bus.p1_health  = h1;
  assign bus.p2_health  = h2;
  assign bus.p1_hit     = hit1;
  assign bus.p2_hit     = hit2;
  assign bus.p1_blocked = blk1;
  assign bus.p2_blocked = blk2;
  assign bus.game_over  = over;
  assign bus.winner     = win;
endmodule

// File: tb/tb_t03_combat_resolver.sv
module tb_t03_combat_resolver;
  localparam int MAXH = 10;
  localparam int DMG  = 2;
  localparam int HSF  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  t03_combat_resolver_if bus();

  t03_combat_resolver #(.MAX_HEALTH(4'd10), .DAMAGE(4'd2), .HITSTOP_FRAMES(3'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-rules model: frozen frames are counted down from HSF, knockouts
  // decided from the post-damage health, one resolution per attack.
  int m_h1, m_h2, m_freeze, m_win;
  bit m_over, m_l1, m_l2, m_hit1, m_hit2, m_blk1, m_blk2;

  always @(posedge clk) begin
    bit a1, a2;
    if (!rst) begin
      m_h1 = MAXH; m_h2 = MAXH; m_freeze = 0; m_win = 0; m_over = 0;
      m_l1 = 0; m_l2 = 0; m_hit1 = 0; m_hit2 = 0; m_blk1 = 0; m_blk2 = 0;
    end else if (bus.finished) begin
      m_hit1 = 0; m_hit2 = 0; m_blk1 = 0; m_blk2 = 0;
      a1 = (bus.p1_state == 2'b01) && !bus.p1_resting && bus.in_range && !m_l1;
      a2 = (bus.p2_state == 2'b01) && !bus.p2_resting && bus.in_range && !m_l2;
      if (m_over) begin
        if (bus.restart) begin
          m_h1 = MAXH; m_h2 = MAXH; m_over = 0; m_win = 0; m_l1 = 0; m_l2 = 0;
        end
      end else if (m_freeze > 0) begin
        m_freeze--;
      end else begin
        if (a1) begin
          if (bus.p2_state == 2'b10) m_blk2 = 1;
          else begin m_hit2 = 1; m_h2 = (m_h2 > DMG) ? m_h2 - DMG : 0; end
          m_l1 = 1;
        end
        if (a2) begin
          if (bus.p1_state == 2'b10) m_blk1 = 1;
          else begin m_hit1 = 1; m_h1 = (m_h1 > DMG) ? m_h1 - DMG : 0; end
          m_l2 = 1;
        end
        if (m_h1 == 0 || m_h2 == 0) begin
          m_over = 1;
          m_win  = (m_h2 == 0 ? 1 : 0) + (m_h1 == 0 ? 2 : 0);
        end else if (a1 || a2) begin
          m_freeze = HSF;
        end
      end
      if (bus.p1_state != 2'b01) m_l1 = 0;
      if (bus.p2_state != 2'b01) m_l2 = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("p1_health",  bus.p1_health,  m_h1);
      check("p2_health",  bus.p2_health,  m_h2);
      check("p1_hit",     bus.p1_hit,     m_hit1);
      check("p2_hit",     bus.p2_hit,     m_hit2);
      check("p1_blocked", bus.p1_blocked, m_blk1);
      check("p2_blocked", bus.p2_blocked, m_blk2);
      check("game_over",  bus.game_over,  m_over);
      check("winner",     bus.winner,     m_win);
    end
  end

  // One frame: inputs applied at negedge, tick consumed on the next posedge.
  task automatic frame(input logic [1:0] s1, input logic r1, input logic [1:0] s2,
                       input logic r2, input logic rng, input logic rs);
    @(negedge clk);
    bus.p1_state = s1; bus.p1_resting = r1;
    bus.p2_state = s2; bus.p2_resting = r2;
    bus.in_range = rng; bus.restart = rs; bus.finished = 1'b1;
    @(posedge clk);
    #1 bus.finished = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic p1_strike();
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    idle(5);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bus.finished = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1; bus.finished = 1'b0;
  endtask

  initial begin
    bus.finished = 1'b0; bus.p1_state = 2'b00; bus.p2_state = 2'b00;
    bus.p1_resting = 1'b1; bus.p2_resting = 1'b1; bus.in_range = 1'b0; bus.restart = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    check("rst_p1_health", bus.p1_health, 10);
    check("rst_p2_health", bus.p2_health, 10);
    check("rst_flags", {bus.p1_hit, bus.p2_hit, bus.p1_blocked, bus.p2_blocked, bus.game_over}, 0);
    check("rst_winner", bus.winner, 0);
    @(negedge clk) rst = 1'b1;

    // single P1 hit, then the attack is held: no second resolution
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("hit1_p2_hit", bus.p2_hit, 1);
    check("hit1_p2_health", bus.p2_health, 8);
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("hit1_pulse_clear", bus.p2_hit, 0);
    for (int i = 0; i < 9; i++) frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("held_no_rehit", bus.p2_health, 8);

    // inert attacks: resting, out of range, invalid state code
    frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    frame(2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    frame(2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("inert_p2_health", bus.p2_health, 8);

    // blocked attack, then re-attack inside the freeze window
    frame(2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    check("blk_p2_blocked", bus.p2_blocked, 1);
    check("blk_p2_health", bus.p2_health, 8);
    frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("freeze_no_hit", bus.p2_health, 8);
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("freeze_end_hit", bus.p2_hit, 1);
    check("freeze_end_health", bus.p2_health, 6);

    // trades down to a double knockout
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      frame(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
      idle(5);
    end
    check("trade_2_2", {bus.p1_health, bus.p2_health}, {4'd2, 4'd2});
    frame(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    check("trade_ko_hits", {bus.p1_hit, bus.p2_hit}, 2'b11);
    check("trade_ko_over", bus.game_over, 1);
    check("trade_ko_winner", bus.winner, 3);
    idle(1);
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("over_frozen", {bus.p1_health, bus.p2_health, bus.p2_hit}, 0);
    frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    check("restart_health", {bus.p1_health, bus.p2_health}, {4'd10, 4'd10});
    check("restart_over", {bus.game_over, bus.winner}, 0);

    // five spaced P1 hits; restart outside OVER must be ignored
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    idle(5);
    check("restart_in_fight", bus.p2_health, 8);
    for (int i = 0; i < 4; i++) p1_strike();
    check("ko_p2_health", bus.p2_health, 0);
    check("ko_winner_p1", bus.winner, 1);
    frame(2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    check("ko_ignore_p2", bus.p1_health, 10);
    frame(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    check("ko_restart", {bus.p2_health, bus.game_over}, {4'd10, 1'b0});

    // live attack with no frame tick: nothing moves
    @(negedge clk);
    bus.p1_state = 2'b01; bus.p1_resting = 1'b0; bus.in_range = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("no_tick_hold", {bus.p2_health, bus.p2_hit}, {4'd10, 1'b0});
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("tick_hit", bus.p2_health, 8);
    idle(1);
    do_reset();
    check("rst_mid_freeze", {bus.p2_health, bus.p2_hit}, {4'd10, 1'b0});
    frame(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("post_rst_eval", bus.p2_health, 8);
    idle(2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/t03_combat_resolver.md
# t03_combat_resolver

Consumes the per-player state/resting outputs of both player FSMs and turns them into game consequences: hit detection, health bookkeeping, hit-stop freeze and game-over. It sits between the two player FSMs and the display/renderer logic, advancing once per frame on the shared `finished` tick. It exposes registered health values and one-frame event flags for drawing.

## Interface
Parameters:
- `MAX_HEALTH`, 4'd10, starting health per player
- `DAMAGE`, 4'd2, health removed per landed unblocked hit
- `HITSTOP_FRAMES`, 3'd4, frames during which no new hits are evaluated after any landed hit

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-low reset; only takes effect on a `clk` edge; overrides everything
- `finished`  input  1  frame tick; all state advances only on clk edges with `finished`=1
- `p1_state`, `p2_state`  input  2  player state: 00 rest, 01 attack, 10 block, 11 invalid (treated as rest)
- `p1_resting`, `p2_resting`  input  1  1 = not in active window; an attack is live only when state=01 and resting=0
- `in_range`  input  1  hitboxes overlap (already frame-synchronous)
- `restart`  input  1  leave OVER and start new round
- `p1_health`, `p2_health`  output  4  current health
- `p1_hit`, `p2_hit`  output  1  player was damaged this frame
- `p1_blocked`, `p2_blocked`  output  1  player blocked an attack this frame
- `game_over`  output  1  round finished
- `winner`  output  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
- Reset (`rst`=0 at clk edge): health = MAX_HEALTH both, all flags 0, `game_over`=0, `winner`=00, hit-stop counter 0, landed latches cleared, FSM = FIGHT.
- FSM states: FIGHT, HITSTOP, OVER.
- Live attack of Pn: `pn_state`=01 && `pn_resting`=0 && `in_range`=1 && landed latch of Pn clear.
- FIGHT, per frame: for each player, if opponent has a live attack:
  - defender state 10 -> defender `blocked`=1, no damage, attacker latch set.
  - otherwise -> defender health -= DAMAGE saturating at 0, defender `hit`=1, attacker latch set.
- Both live attacks in same frame: both evaluated independently (trade; both may take damage).
- Landed latch of Pn clears on the first frame `pn_state` != 01; exactly one resolution per attack.
- Any hit or block in FIGHT -> HITSTOP, counter loaded with HITSTOP_FRAMES-1.
- HITSTOP: no evaluation, flags 0; counter decrements per frame; at 0 -> FIGHT. Latches still clear as above.
- Any health reaching 0 -> OVER (takes priority over HITSTOP): `game_over`=1; winner = 01 if only P2 at 0, 10 if only P1 at 0, 11 if both.
- OVER: health and winner frozen, flags 0; `restart`=1 on a frame -> health reload, `winner`=00, `game_over`=0, latches cleared, FIGHT.
- HITSTOP_FRAMES=0 is illegal; treated as 1.

## Timing
- All outputs registered; update on the clk edge where `finished`=1, otherwise hold.
- Latency: input frame N resolved -> outputs valid after edge N (one frame).
- `*_hit`/`*_blocked` high for exactly one frame interval (set on tick, cleared on next tick).
- `game_over` asserts on the same tick as the final `hit`.
- `rst`=0 with `finished`=1: reset wins.

## Structure
- Shared package `t03_fight_pkg`: player-state encodings (REST/ATTACK/BLOCK), resolver state encoding, winner codes.
- Sub-module `t03_hit_detect`: one attacker/defender pair (live-attack qualify, landed latch, hit/block decision); instantiated twice with roles swapped. Health, hit-stop counter and FSM live in the top.

## Test plan
- Reset with `rst`=0 for 2 clocks -> health 10/10, all flags 0, `winner`=00, `game_over`=0.
- P1 state=01, resting=0, in_range=1, P2 rest, one tick -> `p2_hit`=1 for one frame, `p2_health`=8; attack held 10 frames -> no second hit.
- Same attack with P2 state=10 -> `p2_blocked`=1, `p2_health`=10; next 4 frames no evaluation even if P1 re-attacks.
- Both attack simultaneously in range -> both hit, health 8/8; trade at 2/2 -> 0/0, `game_over`=1, `winner`=11.
- Five spaced P1 hits -> `p2_health` 0, `winner`=01; further attacks ignored; `restart`=1 -> 10/10, FIGHT.
- `finished`=0 for many cycles with live attack -> no output change; `rst`=0 mid-HITSTOP -> full reset next edge.
